ram_queue_mc: RTL and testbench
===============================

Name: ram_queue_mc

Overview:
Multi-channel FIFO. NUM_CHANNELS independent logical queues share one ram_SRW instance, each owning a fixed region of 2**LOG2_DEPTH entries. One write and one read per cycle, to any channels. Per-channel full/empty/occupancy flags. Unlike the single-queue design, all 2**LOG2_DEPTH slots of a channel are usable, because count registers are used instead of head == tail-1. Sits between multi-source producers (per-thread/per-unit streams) and a shared consumer arbiter.

Parameters:
DATA_WIDTH, 8, bits per entry
LOG2_DEPTH, 2, log2 of entries per channel
NUM_CHANNELS, 4, number of logical queues (>=1, need not be a power of 2)
CH_W, $clog2(NUM_CHANNELS) (min 1), channel index width (derived, localparam)
AF_THRESH, 2**LOG2_DEPTH-1, almost-full level (used only with the optional feature)

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
wvalid_i  in  1  write request
wchan_i  in  CH_W  target channel of write
wdata_i  in  DATA_WIDTH  write data
wready_o  out  1  write accepted this cycle if wvalid_i
rready_i  in  1  read request
rchan_i  in  CH_W  source channel of read
rvalid_o  out  1  rdata_o/rchan_o valid (one cycle after accepted read)
rdata_o  out  DATA_WIDTH  read data
rchan_o  out  CH_W  channel that rdata_o came from
full_o  out  NUM_CHANNELS  per-channel full
empty_o  out  NUM_CHANNELS  per-channel empty
count_o  out  NUM_CHANNELS*(LOG2_DEPTH+1)  per-channel occupancy, channel c at [c*(LOG2_DEPTH+1) +: LOG2_DEPTH+1]

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n), clock clk.
- Reset: all head/tail pointers = 0, counts = 0, empty_o = all 1, full_o = 0, rvalid_o = 0, rchan_o = 0. RAM contents are not reset. rdata_o is undefined until the first rvalid_o.
- Reset asserted mid-operation: all channels are emptied immediately. An in-flight read is dropped, and rvalid_o is forced to 0 asynchronously.
- wready_o = (wchan_i < NUM_CHANNELS) & ~full[wchan_i]. It is combinational and does not depend on wvalid_i.
- Write accept wr_acc = wvalid_i & wready_o. The write goes to RAM address {wchan_i, head[wchan_i]}, and head then increments modulo 2**LOG2_DEPTH.
- Read accept rd_acc = rready_i & (rchan_i < NUM_CHANNELS) & ~empty[rchan_i]. The read uses RAM address {rchan_i, tail[rchan_i]}, and tail then increments with wrap.
- Read latency is 1 cycle. rvalid_o is registered: high in the cycle after rd_acc, otherwise low. rchan_o is registered with it. There is no back-pressure on the read output: the consumer must take the data that cycle.
- Flags are evaluated on pre-edge state:
  - Write to an empty channel plus read of that channel in the same cycle: the read is refused (no bypass).
  - Write to a full channel plus read of that channel in the same cycle: the write is refused.
- Read and write of the same non-empty, non-full channel in one cycle: both are accepted and the count is unchanged.
- Different channels in one cycle: independent. Each count updates by +1 or -1.
- Count range is 0..2**LOG2_DEPTH. full = (count == 2**LOG2_DEPTH), empty = (count == 0). All flags are registered-state derived, with no combinational path from the inputs.
- Out-of-range channel index: write not accepted, read not accepted, no state change.
- RAM: ram_SRW with SIZE = NUM_CHANNELS*2**LOG2_DEPTH, ADDR_WIDTH = CH_W+LOG2_DEPTH, ce_i = wr_acc | rd_acc, we_i = wr_acc.

Optional Feature:
RAM_QUEUE_MC_ALMOST_FULL_EN
- Defined: extra port almost_full_o (out, NUM_CHANNELS). Bit c = (count[c] >= AF_THRESH). It is registered-state derived and resets to 0.
- Undefined: the port and its logic are absent, and AF_THRESH is unused.

Decomposition:
- Package ram_queue_mc_pkg holds:
  - a function computing CH_W from NUM_CHANNELS;
  - the count width expression LOG2_DEPTH+1;
  - the typedef for one channel's pointer/count record {head, tail, count}.
- One sub-module, ram_queue_mc_ptrs: a single channel's pointer and count bank, with inputs push/pop and outputs waddr/raddr/full/empty/count. It is instantiated NUM_CHANNELS times via generate.
- The top level holds the channel decode, the ram_SRW instance and the read-output registers.

Test Plan:
- Reset, then fill ch2 with 4 writes (0xA0..0xA3) at default params → count_o[ch2] = 4, full_o = 4'b0100, 5th write has wready_o = 0. Read 4 times → 0xA0..0xA3 with rchan_o = 2, each one cycle after rready_i.
- Interleave writes to ch0/ch1/ch3 (values 0x10,0x20,0x30,0x11,...) → per-channel order preserved, no cross-channel data.
- Same-cycle read+write on ch1 holding 2 entries → count stays 2 and the read returns the oldest entry. Same-cycle read+write on empty ch0 → read refused (rvalid_o = 0 next cycle), count becomes 1.
- Wrap: 10 push/pop pairs on ch3 with values 0..9 → outputs 0..9 in order, pointers wrap, count ends at 0.
- NUM_CHANNELS = 3, wchan_i = 3 → wready_o = 0 and no state change. Also assert reset_n mid-read → rvalid_o drops immediately and empty_o is all ones.
- With RAM_QUEUE_MC_ALMOST_FULL_EN, AF_THRESH = 3 → almost_full_o[c] rises on the 3rd write and falls after 1 read.

Source files
------------

// File: rtl/ram_queue_mc_pkg.sv
// Shared sizing helpers for the multi-channel RAM-backed queue.
package ram_queue_mc_pkg;

    // Channel index width, never narrower than one bit.
    function automatic int ch_w_f(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

    // Occupancy needs one extra bit so a completely full channel is representable.
    function automatic int cnt_w_f(input int log2_depth);
        return log2_depth + 1;
    endfunction

endpackage

// File: rtl/ram_SRW.sv
// Synchronous single-clock RAM: one write port, one registered read port, shared enable.
module ram_SRW #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [SIZE];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: storage has no reset so it maps onto block RAM; only control state is reset.
    always_ff @(posedge clk) begin
        if (ce_i) begin
            if (we_i) mem_q[waddr_i] <= wdata_i;
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_queue_mc_ptrs.sv
// Head/tail/count bank for one logical channel; push and pop are pre-qualified by the top.
module ram_queue_mc_ptrs
    import ram_queue_mc_pkg::*;
#(
    parameter  int LOG2_DEPTH = 2,
    localparam int CNT_W      = cnt_w_f(LOG2_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [LOG2_DEPTH-1:0] waddr_o,
    output logic [LOG2_DEPTH-1:0] raddr_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o
);

    typedef struct packed {
        logic [LOG2_DEPTH-1:0] head;
        logic [LOG2_DEPTH-1:0] tail;
        logic [CNT_W-1:0]      count;
    } chan_rec_t;

    chan_rec_t rec_q, rec_d;

    // NOTE: defaulting every field first keeps this block free of inferred latches.
    always_comb begin
        rec_d = rec_q;
        if (push_i) rec_d.head = rec_q.head + 1'b1;
        if (pop_i)  rec_d.tail = rec_q.tail + 1'b1;
        case ({push_i, pop_i})
            2'b10:   rec_d.count = rec_q.count + 1'b1;
            2'b01:   rec_d.count = rec_q.count - 1'b1;
            default: rec_d.count = rec_q.count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rec_q <= '0;
        else          rec_q <= rec_d;
    end

    assign waddr_o = rec_q.head;
    assign raddr_o = rec_q.tail;
    assign count_o = rec_q.count;
    assign full_o  = (rec_q.count == CNT_W'(2**LOG2_DEPTH));
    assign empty_o = (rec_q.count == '0);

endmodule

// File: rtl/ram_queue_mc.sv
// NUM_CHANNELS logical FIFOs sharing one RAM, one write and one read per cycle.
// Define RAM_QUEUE_MC_ALMOST_FULL_EN to add the per-channel almost_full_o output.
module ram_queue_mc
    import ram_queue_mc_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int LOG2_DEPTH   = 2,
    parameter  int NUM_CHANNELS = 4,
`ifdef RAM_QUEUE_MC_ALMOST_FULL_EN
    parameter  int AF_THRESH    = 2**LOG2_DEPTH - 1,
`endif
    localparam int CH_W         = ch_w_f(NUM_CHANNELS),
    localparam int CNT_W        = cnt_w_f(LOG2_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wvalid_i,
    input  logic [CH_W-1:0]               wchan_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    output logic                          wready_o,
    input  logic                          rready_i,
    input  logic [CH_W-1:0]               rchan_i,
    output logic                          rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [CH_W-1:0]               rchan_o,
    output logic [NUM_CHANNELS-1:0]       full_o,
    output logic [NUM_CHANNELS-1:0]       empty_o,
    output logic [NUM_CHANNELS*CNT_W-1:0] count_o
`ifdef RAM_QUEUE_MC_ALMOST_FULL_EN
   ,output logic [NUM_CHANNELS-1:0]       almost_full_o
`endif
);

    localparam int AW = CH_W + LOG2_DEPTH;

    logic [NUM_CHANNELS-1:0] full_v, empty_v, push_v, pop_v;
    logic [LOG2_DEPTH-1:0]   waddr_v [NUM_CHANNELS];
    logic [LOG2_DEPTH-1:0]   raddr_v [NUM_CHANNELS];
    logic                    wr_range, rd_range, wr_acc, rd_acc;
    logic                    rvalid_q, rvalid_d;
    logic [CH_W-1:0]         rchan_q, rchan_d;

    // Acceptance looks only at registered flags, so a same-cycle write never enables a read.
    assign wr_range = int'(wchan_i) < NUM_CHANNELS;
    assign rd_range = int'(rchan_i) < NUM_CHANNELS;
    assign wready_o = wr_range && !full_v[wchan_i];
    assign wr_acc   = wvalid_i && wready_o;
    assign rd_acc   = rready_i && rd_range && !empty_v[rchan_i];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        assign push_v[c] = wr_acc && (wchan_i == CH_W'(c));
        assign pop_v[c]  = rd_acc && (rchan_i == CH_W'(c));

        ram_queue_mc_ptrs #(.LOG2_DEPTH(LOG2_DEPTH)) u_ptrs (
            .clk     (clk),
            .reset_n (reset_n),
            .push_i  (push_v[c]),
            .pop_i   (pop_v[c]),
            .waddr_o (waddr_v[c]),
            .raddr_o (raddr_v[c]),
            .full_o  (full_v[c]),
            .empty_o (empty_v[c]),
            .count_o (count_o[c*CNT_W +: CNT_W])
        );

`ifdef RAM_QUEUE_MC_ALMOST_FULL_EN
        assign almost_full_o[c] = (count_o[c*CNT_W +: CNT_W] >= CNT_W'(AF_THRESH));
`endif
    end

    assign full_o  = full_v;
    assign empty_o = empty_v;

    ram_SRW #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (NUM_CHANNELS * 2**LOG2_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk     (clk),
        .ce_i    (wr_acc || rd_acc),
        .we_i    (wr_acc),
        .waddr_i ({wchan_i, waddr_v[wchan_i]}),
        .raddr_i ({rchan_i, raddr_v[rchan_i]}),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o)
    );

    always_comb begin
        rvalid_d = rd_acc;
        rchan_d  = rd_acc ? rchan_i : rchan_q;
    end

    // Reset clears rvalid asynchronously, dropping any read still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= 1'b0;
            rchan_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rchan_q  <= rchan_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rchan_o  = rchan_q;

endmodule

// File: tb/tb_ram_queue_mc.sv
// Self-checking bench for ram_queue_mc: directed table, corner sequences, random vs queue model.
module tb_ram_queue_mc;

    localparam int NCH   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wvalid_i = 1'b0, rready_i = 1'b0;
    logic [1:0]  wchan_i = '0, rchan_i = '0;
    logic [7:0]  wdata_i = '0;
    logic        wready_o, rvalid_o;
    logic [7:0]  rdata_o;
    logic [1:0]  rchan_o;
    logic [3:0]  full_o, empty_o;
    logic [11:0] count_o;

    // Second instance with a non-power-of-two channel count.
    logic        w3v = 1'b0, r3r = 1'b0;
    logic [1:0]  w3c = '0, r3c = '0;
    logic [7:0]  w3d = '0;
    logic        wready3, rvalid3;
    logic [7:0]  rdata3;
    logic [1:0]  rchan3;
    logic [2:0]  full3, empty3;
    logic [8:0]  count3;

`ifdef RAM_QUEUE_MC_ALMOST_FULL_EN
    logic [3:0] almost_full_o;
    logic [2:0] almost_full3;
`endif

    always #5 clk = ~clk;

    ram_queue_mc dut (
        .clk(clk), .reset_n(reset_n),
        .wvalid_i(wvalid_i), .wchan_i(wchan_i), .wdata_i(wdata_i), .wready_o(wready_o),
        .rready_i(rready_i), .rchan_i(rchan_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .rchan_o(rchan_o), .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
`ifdef RAM_QUEUE_MC_ALMOST_FULL_EN
       ,.almost_full_o(almost_full_o)
`endif
    );

    ram_queue_mc #(.NUM_CHANNELS(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .wvalid_i(w3v), .wchan_i(w3c), .wdata_i(w3d), .wready_o(wready3),
        .rready_i(r3r), .rchan_i(r3c), .rvalid_o(rvalid3), .rdata_o(rdata3),
        .rchan_o(rchan3), .full_o(full3), .empty_o(empty3), .count_o(count3)
`ifdef RAM_QUEUE_MC_ALMOST_FULL_EN
       ,.almost_full_o(almost_full3)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one plain FIFO per channel.
    int mq [NCH][$];

    logic       s_wready, s_rvalid;
    logic [7:0] s_rdata;
    logic [1:0] s_rchan;

    function automatic logic [2:0] cnt(input int c);
        return count_o[c*3 +: 3];
    endfunction

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic wv, input int wc, input logic [7:0] wd,
                        input logic rr, input int rc);
        logic e_wready, e_wr, e_rd;
        int   e_data;
        wvalid_i = wv; wchan_i = 2'(wc); wdata_i = wd;
        rready_i = rr; rchan_i = 2'(rc);
        #1;
        e_wready = mq[wc].size() < DEPTH;
        s_wready = wready_o;
        check("wready", wready_o, e_wready);
        e_wr = wv && e_wready;
        e_rd = rr && (mq[rc].size() > 0);
        @(posedge clk);
        #1;
        e_data = 0;
        if (e_rd) e_data = mq[rc].pop_front();
        if (e_wr) mq[wc].push_back(int'(wd));
        s_rvalid = rvalid_o; s_rdata = rdata_o; s_rchan = rchan_o;
        check("rvalid", rvalid_o, e_rd);
        if (e_rd) begin
            check("rdata", rdata_o, e_data);
            check("rchan", rchan_o, rc);
        end
        for (int c = 0; c < NCH; c++) begin
            check("count", cnt(c), mq[c].size());
            check("full", full_o[c], mq[c].size() == DEPTH);
            check("empty", empty_o[c], mq[c].size() == 0);
`ifdef RAM_QUEUE_MC_ALMOST_FULL_EN
            check("almost_full", almost_full_o[c], mq[c].size() >= DEPTH - 1);
`endif
        end
    endtask

    typedef struct {
        logic       wv;
        logic [1:0] wc;
        logic [7:0] wd;
        logic       rr;
        logic [1:0] rc;
        logic       e_wready;
        logic       e_rvalid;
        logic [7:0] e_rdata;
        logic [3:0] e_full;
        logic [2:0] e_cnt2;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Fill channel 2 to capacity, refuse a fifth write, then drain it in order.
        tbl[0] = '{1'b1, 2'd2, 8'hA0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'b0000, 3'd1};
        tbl[1] = '{1'b1, 2'd2, 8'hA1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'b0000, 3'd2};
        tbl[2] = '{1'b1, 2'd2, 8'hA2, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'b0000, 3'd3};
        tbl[3] = '{1'b1, 2'd2, 8'hA3, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'b0100, 3'd4};
        tbl[4] = '{1'b1, 2'd2, 8'hA4, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'b0100, 3'd4};
        tbl[5] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b1, 8'hA0, 4'b0000, 3'd3};
        tbl[6] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b1, 8'hA1, 4'b0000, 3'd2};
        tbl[7] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b1, 8'hA2, 4'b0000, 3'd1};
        tbl[8] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b1, 8'hA3, 4'b0000, 3'd0};
        tbl[9] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00, 4'b0000, 3'd0};

        #12;
        check("reset_rvalid", rvalid_o, 0);
        check("reset_rchan", rchan_o, 0);
        check("reset_empty", empty_o, 4'b1111);
        check("reset_full", full_o, 4'b0000);
        check("reset_count", count_o, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            step(tbl[i].wv, tbl[i].wc, tbl[i].wd, tbl[i].rr, tbl[i].rc);
            check("tbl_wready", s_wready, tbl[i].e_wready);
            check("tbl_rvalid", s_rvalid, tbl[i].e_rvalid);
            if (tbl[i].e_rvalid) begin
                check("tbl_rdata", s_rdata, tbl[i].e_rdata);
                check("tbl_rchan", s_rchan, 2);
            end
            check("tbl_full", full_o, tbl[i].e_full);
            check("tbl_cnt2", cnt(2), tbl[i].e_cnt2);
        end

        // Interleaved writes to channels 0, 1, 3 then interleaved reads.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 0, 8'(8'h10 + k), 1'b0, 0);
            step(1'b1, 1, 8'(8'h20 + k), 1'b0, 0);
            step(1'b1, 3, 8'(8'h30 + k), 1'b0, 0);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 0, 8'h00, 1'b1, 3);
            check("ilv_ch3", s_rdata, 8'h30 + k);
            step(1'b0, 0, 8'h00, 1'b1, 0);
            check("ilv_ch0", s_rdata, 8'h10 + k);
            step(1'b0, 0, 8'h00, 1'b1, 1);
            check("ilv_ch1", s_rdata, 8'h20 + k);
        end

        // Simultaneous read and write of channel 1 holding two entries.
        step(1'b1, 1, 8'h40, 1'b0, 0);
        step(1'b1, 1, 8'h41, 1'b0, 0);
        step(1'b1, 1, 8'h42, 1'b1, 1);
        check("rw_same_rvalid", s_rvalid, 1);
        check("rw_same_rdata", s_rdata, 8'h40);
        check("rw_same_cnt1", cnt(1), 2);
        step(1'b0, 0, 8'h00, 1'b1, 1);
        step(1'b0, 0, 8'h00, 1'b1, 1);

        // Write plus read of empty channel 0: read refused, no bypass.
        step(1'b1, 0, 8'h50, 1'b1, 0);
        check("rw_empty_rvalid", s_rvalid, 0);
        check("rw_empty_cnt0", cnt(0), 1);
        step(1'b0, 0, 8'h00, 1'b1, 0);
        check("rw_empty_drain", s_rdata, 8'h50);

        // Ten push/pop pairs on channel 3 exercise pointer wrap.
        step(1'b1, 3, 8'd0, 1'b0, 0);
        for (int i = 1; i < 10; i++) begin
            step(1'b1, 3, 8'(i), 1'b1, 3);
            check("wrap_rdata", s_rdata, i - 1);
        end
        step(1'b0, 0, 8'h00, 1'b1, 3);
        check("wrap_last", s_rdata, 9);
        check("wrap_cnt3", cnt(3), 0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        wvalid_i = 1'b0; rready_i = 1'b0;

        // Out-of-range channel on the three-channel instance.
        w3v = 1'b1; w3c = 2'd2; w3d = 8'h77;
        #1;
        check("oor_wready_ok", wready3, 1);
        @(posedge clk); #1;
        w3c = 2'd3; w3d = 8'h99; r3r = 1'b1; r3c = 2'd3;
        #1;
        check("oor_wready", wready3, 0);
        @(posedge clk); #1;
        check("oor_rvalid", rvalid3, 0);
        check("oor_count", count3, 9'b001_000_000);
        check("oor_empty", empty3, 3'b011);
        check("oor_full", full3, 3'b000);
        w3v = 1'b0; r3c = 2'd2;
        @(posedge clk); #1;
        check("oor_rd_valid", rvalid3, 1);
        check("oor_rd_data", rdata3, 8'h77);
        check("oor_rd_chan", rchan3, 2);
        r3r = 1'b0;

`ifdef RAM_QUEUE_MC_ALMOST_FULL_EN
        // Almost-full rises on the third entry and falls after one read.
        for (int c = 0; c < NCH; c++)
            while (mq[c].size() > 0) step(1'b0, 0, 8'h00, 1'b1, c);
        step(1'b1, 0, 8'h61, 1'b0, 0);
        check("af_1", almost_full_o[0], 0);
        step(1'b1, 0, 8'h62, 1'b0, 0);
        check("af_2", almost_full_o[0], 0);
        step(1'b1, 0, 8'h63, 1'b0, 0);
        check("af_3", almost_full_o[0], 1);
        step(1'b0, 0, 8'h00, 1'b1, 0);
        check("af_read", almost_full_o[0], 0);
`endif

        // Reset asserted while a read result is on the output.
        step(1'b1, 1, 8'h88, 1'b0, 0);
        step(1'b0, 0, 8'h00, 1'b1, 1);
        check("mid_rvalid_before", s_rvalid, 1);
        wvalid_i = 1'b0; rready_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rvalid", rvalid_o, 0);
        check("mid_empty", empty_o, 4'b1111);
        check("mid_full", full_o, 4'b0000);
        check("mid_count", count_o, 0);
        check("mid_empty3", empty3, 3'b111);
        for (int c = 0; c < NCH; c++) mq[c].delete();
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 2, 8'h5A, 1'b0, 0);
        step(1'b0, 0, 8'h00, 1'b1, 2);
        check("post_reset_rdata", s_rdata, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
